// File: rtl/mcpu_pkg.sv
// Shared definitions for the mcpu multicycle core: opcodes, FSM states and
// instruction field positions.
package mcpu_pkg;

  localparam logic [3:0] OP_ADD  = 4'h0;
  localparam logic [3:0] OP_SUB  = 4'h1;
  localparam logic [3:0] OP_AND  = 4'h2;
  localparam logic [3:0] OP_OR   = 4'h3;
  localparam logic [3:0] OP_ADDI = 4'h4;
  localparam logic [3:0] OP_MUL  = 4'h5;
  localparam logic [3:0] OP_MFHI = 4'h6;
  localparam logic [3:0] OP_MFLO = 4'h7;
  localparam logic [3:0] OP_BEQ  = 4'h8;
  localparam logic [3:0] OP_JMP  = 4'h9;
  localparam logic [3:0] OP_HALT = 4'hF;

  localparam int OP_HI = 15;
  localparam int OP_LO = 12;
  localparam int FA_HI = 11;
  localparam int FA_LO = 8;
  localparam int FB_HI = 7;
  localparam int FB_LO = 4;
  localparam int FC_HI = 3;
  localparam int FC_LO = 0;
  localparam int IMM_W = 12;
  localparam int RF_AW = 4;

  typedef enum logic [2:0] {
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_MULT,
    S_WB,
    S_HALT
  } state_t;

endpackage

// File: rtl/mcpu_if.sv
// Instruction-memory fetch port: req/addr held by the core until ack.
interface mcpu_if #(
  parameter int AW = 12
) ();

  logic          imem_req;
  logic [AW-1:0] imem_addr;
  logic          imem_ack;
  logic [15:0]   imem_rdata;

  modport master (
    output imem_req,
    output imem_addr,
    input  imem_ack,
    input  imem_rdata
  );

  modport slave (
    input  imem_req,
    input  imem_addr,
    output imem_ack,
    output imem_rdata
  );

endinterface

// File: rtl/mcpu_regfile.sv
// General-purpose register file: two combinational read ports, one
// synchronous write port, synchronous clear.
module mcpu_regfile
  import mcpu_pkg::*;
#(
  parameter int DW   = 16,
  parameter int NREG = 16
) (
  input  logic             CLK,
  input  logic             RST,
  input  logic [RF_AW-1:0] raddrA,
  input  logic [RF_AW-1:0] raddrB,
  output logic [DW-1:0]    rdataA,
  output logic [DW-1:0]    rdataB,
  input  logic             we,
  input  logic [RF_AW-1:0] waddr,
  input  logic [DW-1:0]    wdata
);

  logic [DW-1:0] regs [NREG];

  always_ff @(posedge CLK) begin
    if (RST) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= '0;
      end
    end else if (we) begin
      regs[waddr] <= wdata;
    end
  end

  assign rdataA = regs[raddrA];
  assign rdataB = regs[raddrB];

endmodule

// File: rtl/mcpu_core.sv
// Multicycle 16-bit-instruction core: req/ack fetch, FSM-sequenced execute,
// iterative HI/LO multiplier and a write-back observation port.
module mcpu_core
  import mcpu_pkg::*;
#(
  parameter int DW   = 16,
  parameter int AW   = 12,
  parameter int NREG = 16
) (
  input  logic             CLK,
  input  logic             RST,
  mcpu_if.master           imem,
  output logic [AW-1:0]    pc,
  output logic             halted,
  output logic             wb_valid,
  output logic [RF_AW-1:0] wb_addr,
  output logic [DW-1:0]    wb_data
);

  localparam int CW = $clog2(DW);

  state_t state;
  state_t nextState;

  logic [15:0]      ir;
  logic [DW-1:0]    opA;
  logic [DW-1:0]    opB;
  logic [DW-1:0]    resQ;
  logic [DW-1:0]    hi;
  logic [DW-1:0]    lo;
  logic [2*DW-1:0]  mcand;
  logic [2*DW-1:0]  acc;
  logic [2*DW-1:0]  accNext;
  logic [DW-1:0]    mplier;
  logic [CW-1:0]    mulCnt;
  logic             mulLast;
  logic             fetchEn;
  logic             imemReq;

  logic [3:0]       irOp;
  logic [3:0]       irA;
  logic [3:0]       irB;
  logic [3:0]       irC;
  logic [AW-1:0]    pcInc;
  logic [AW-1:0]    jmpTarget;

  logic [RF_AW-1:0] rfAddrA;
  logic [DW-1:0]    rdA;
  logic [DW-1:0]    rdB;
  logic             rfWe;

  assign irOp = ir[OP_HI:OP_LO];
  assign irA  = ir[FA_HI:FA_LO];
  assign irB  = ir[FB_HI:FB_LO];
  assign irC  = ir[FC_HI:FC_LO];

  assign pcInc = pc + AW'(1);

  always_comb begin
    jmpTarget = pc;
    jmpTarget[IMM_W-1:0] = ir[IMM_W-1:0];
  end

  assign accNext = acc + (mplier[0] ? mcand : '0);
  assign mulLast = (mulCnt == CW'(DW - 1));

  // Port A doubles as the BEQ target read (R[c]) while in EXEC.
  assign rfAddrA = (state == S_EXEC) ? irC : irA;
  assign rfWe    = (state == S_WB);

  mcpu_regfile #(
    .DW   (DW),
    .NREG (NREG)
  ) u_regfile (
    .CLK    (CLK),
    .RST    (RST),
    .raddrA (rfAddrA),
    .raddrB (irB),
    .rdataA (rdA),
    .rdataB (rdB),
    .we     (rfWe),
    .waddr  (irC),
    .wdata  (resQ)
  );

  always_ff @(posedge CLK) begin
    if (RST) begin
      state <= S_FETCH;
    end else begin
      state <= nextState;
    end
  end

  always_comb begin
    nextState = state;
    imemReq   = 1'b0;
    halted    = 1'b0;
    wb_valid  = 1'b0;
    wb_addr   = '0;
    wb_data   = '0;
    case (state)
      S_FETCH: begin
        imemReq = fetchEn;
        if (fetchEn && imem.imem_ack) begin
          nextState = S_DECODE;
        end
      end
      S_DECODE: nextState = S_EXEC;
      S_EXEC: begin
        case (irOp)
          OP_ADD, OP_SUB, OP_AND, OP_OR,
          OP_ADDI, OP_MFHI, OP_MFLO: nextState = S_WB;
          OP_MUL:                    nextState = S_MULT;
          OP_HALT:                   nextState = S_HALT;
          default:                   nextState = S_FETCH;
        endcase
      end
      S_MULT: begin
        if (mulLast) begin
          nextState = S_FETCH;
        end
      end
      S_WB: begin
        wb_valid  = 1'b1;
        wb_addr   = irC;
        wb_data   = resQ;
        nextState = S_FETCH;
      end
      S_HALT:  halted = 1'b1;
      default: nextState = S_FETCH;
    endcase
  end

  // fetchEn keeps req low for the first cycle out of reset.
  always_ff @(posedge CLK) begin
    if (RST) begin
      fetchEn <= 1'b0;
      pc      <= '0;
      ir      <= '0;
      opA     <= '0;
      opB     <= '0;
      resQ    <= '0;
      hi      <= '0;
      lo      <= '0;
      mcand   <= '0;
      acc     <= '0;
      mplier  <= '0;
      mulCnt  <= '0;
    end else begin
      fetchEn <= 1'b1;
      case (state)
        S_FETCH: begin
          if (fetchEn && imem.imem_ack) begin
            ir <= imem.imem_rdata;
          end
        end
        S_DECODE: begin
          opA <= rdA;
          opB <= rdB;
        end
        S_EXEC: begin
          case (irOp)
            OP_ADD:  resQ <= opA + opB;
            OP_SUB:  resQ <= opA - opB;
            OP_AND:  resQ <= opA & opB;
            OP_OR:   resQ <= opA | opB;
            OP_ADDI: resQ <= opA + DW'(irB);
            OP_MFHI: resQ <= hi;
            OP_MFLO: resQ <= lo;
            OP_MUL: begin
              acc    <= '0;
              mcand  <= {{DW{1'b0}}, opA};
              mplier <= opB;
              mulCnt <= '0;
            end
            OP_BEQ:  pc <= (opA == opB) ? rdA[AW-1:0] : pcInc;
            OP_JMP:  pc <= jmpTarget;
            OP_HALT: ;
            default: pc <= pcInc;
          endcase
        end
        // HI/LO only change on the final step so an aborted multiply leaves no trace.
        S_MULT: begin
          if (mulLast) begin
            {hi, lo} <= accNext;
            pc       <= pcInc;
          end else begin
            acc    <= accNext;
            mcand  <= mcand << 1;
            mplier <= mplier >> 1;
            mulCnt <= mulCnt + CW'(1);
          end
        end
        S_WB:    pc <= pcInc;
        default: ;
      endcase
    end
  end

  assign imem.imem_req  = imemReq;
  assign imem.imem_addr = pc;

endmodule

// File: tb/tb_mcpu_core.sv
// Directed bench for mcpu_core: instruction memory with programmable wait
// states, write-back and fetch logging, and hand-computed expectations.
module tb_mcpu_core;

  logic        CLK;
  logic        RST;
  logic        halted;
  logic        wbValid;
  logic [3:0]  wbAddr;
  logic [15:0] wbData;
  logic [11:0] pc;

  mcpu_if #(.AW(12)) bus ();

  mcpu_core #(.DW(16), .AW(12), .NREG(16)) dut (
    .CLK      (CLK),
    .RST      (RST),
    .imem     (bus),
    .pc       (pc),
    .halted   (halted),
    .wb_valid (wbValid),
    .wb_addr  (wbAddr),
    .wb_data  (wbData)
  );

  logic [15:0] mem [4096];
  int unsigned maxWait;
  logic        holdAck;
  int unsigned waitLeft;
  int          cycCnt;
  int          checks;
  int          errors;

  logic [19:0] wbQ[$];
  int          wbCyc[$];
  logic [11:0] fetchQ[$];

  logic        pendPrev;
  logic        rstPrev;
  logic [11:0] addrPrev;

  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  assign bus.imem_ack   = bus.imem_req && (waitLeft == 0) && !holdAck;
  assign bus.imem_rdata = mem[bus.imem_addr];

  always @(posedge CLK) begin
    cycCnt <= cycCnt + 1;
    if (!bus.imem_req || bus.imem_ack) begin
      waitLeft <= $urandom_range(maxWait, 0);
    end else if (waitLeft != 0) begin
      waitLeft <= waitLeft - 1;
    end
  end

  // Logs fetches and write-backs; checks req/addr are held while waiting for ack.
  always @(negedge CLK) begin
    if (!RST) begin
      if (bus.imem_req && bus.imem_ack) fetchQ.push_back(bus.imem_addr);
      if (wbValid) begin
        wbQ.push_back({wbAddr, wbData});
        wbCyc.push_back(cycCnt);
      end
      if (pendPrev && !rstPrev) begin
        checks++;
        assert (bus.imem_req === 1'b1 && bus.imem_addr === addrPrev) else begin
          errors++;
          $error("[TB] FAIL req_hold observed req=%b addr=%h expected req=1 addr=%h",
                 bus.imem_req, bus.imem_addr, addrPrev);
        end
      end
    end
    pendPrev = bus.imem_req && !bus.imem_ack;
    addrPrev = bus.imem_addr;
    rstPrev  = RST;
  end

  task automatic applyStimulus(input logic rstVal, input int cycles);
    RST = rstVal;
    repeat (cycles) @(posedge CLK);
    #1;
  endtask

  task automatic checkOutput(input string tag, input logic [31:0] observed,
                             input logic [31:0] expected);
    checks++;
    assert (observed === expected) else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  task automatic clearLogs();
    wbQ.delete();
    wbCyc.delete();
    fetchQ.delete();
  endtask

  task automatic clearMem();
    for (int i = 0; i < 4096; i++) mem[i] = 16'h0000;
  endtask

  task automatic runUntilHalt(input int bound);
    for (int i = 0; i < bound && !halted; i++) applyStimulus(1'b0, 1);
  endtask

  initial begin
    #400000;
    $display("[TB] FAIL watchdog timeout");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    logic [11:0] expFetch [11];
    int          base;
    logic        reqSeen;

    RST      = 1'b1;
    maxWait  = 0;
    holdAck  = 1'b0;
    cycCnt   = 0;
    checks   = 0;
    errors   = 0;
    waitLeft = 0;
    pendPrev = 1'b0;
    rstPrev  = 1'b1;
    addrPrev = '0;

    // Zero-wait ADDI/ADDI/ADD then HALT.
    clearMem();
    mem[0] = 16'h4051;
    mem[1] = 16'h4032;
    mem[2] = 16'h0123;
    mem[3] = 16'hF000;
    applyStimulus(1'b1, 2);
    checkOutput("rst_pc", 32'(pc), 32'h0);
    checkOutput("rst_req", 32'(bus.imem_req), 32'h0);
    checkOutput("rst_halted", 32'(halted), 32'h0);
    checkOutput("rst_wb_valid", 32'(wbValid), 32'h0);
    checkOutput("rst_wb_addr", 32'(wbAddr), 32'h0);
    checkOutput("rst_wb_data", 32'(wbData), 32'h0);
    clearLogs();
    applyStimulus(1'b0, 1);
    base = cycCnt;
    checkOutput("t1_req_first", 32'(bus.imem_req), 32'h1);
    checkOutput("t1_addr_first", 32'(bus.imem_addr), 32'h0);
    applyStimulus(1'b0, 12);
    checkOutput("t1_pc_12cyc", 32'(pc), 32'h3);
    checkOutput("t1_wb_count", 32'(wbQ.size()), 32'd3);
    checkOutput("t1_wb0", 32'(wbQ[0]), 32'h1_0005);
    checkOutput("t1_wb1", 32'(wbQ[1]), 32'h2_0003);
    checkOutput("t1_wb2", 32'(wbQ[2]), 32'h3_0008);
    checkOutput("t1_wb0_latency", 32'(wbCyc[0] - base), 32'd3);
    applyStimulus(1'b0, 10);
    checkOutput("t1_halted", 32'(halted), 32'h1);
    checkOutput("t1_halt_pc", 32'(pc), 32'h3);
    reqSeen = 1'b0;
    for (int i = 0; i < 100; i++) begin
      applyStimulus(1'b0, 1);
      reqSeen |= bus.imem_req;
    end
    checkOutput("t1_halt_req_low", 32'(reqSeen), 32'h0);
    checkOutput("t1_halt_wb_count", 32'(wbQ.size()), 32'd3);

    // Same program with 0-3 random wait states.
    maxWait = 3;
    applyStimulus(1'b1, 2);
    clearLogs();
    applyStimulus(1'b0, 1);
    runUntilHalt(300);
    checkOutput("t2_halted", 32'(halted), 32'h1);
    checkOutput("t2_wb_count", 32'(wbQ.size()), 32'd3);
    checkOutput("t2_wb0", 32'(wbQ[0]), 32'h1_0005);
    checkOutput("t2_wb1", 32'(wbQ[1]), 32'h2_0003);
    checkOutput("t2_wb2", 32'(wbQ[2]), 32'h3_0008);
    maxWait = 0;

    // 0xFFFF * 0xFFFF through MUL, then MFHI/MFLO.
    applyStimulus(1'b1, 2);
    clearMem();
    mem[0] = 16'h4014;
    mem[1] = 16'h1041;
    mem[2] = 16'h1042;
    mem[3] = 16'h5120;
    mem[4] = 16'h6005;
    mem[5] = 16'h7006;
    mem[6] = 16'hF000;
    clearLogs();
    applyStimulus(1'b0, 1);
    runUntilHalt(300);
    checkOutput("t3_halted", 32'(halted), 32'h1);
    checkOutput("t3_wb_count", 32'(wbQ.size()), 32'd5);
    checkOutput("t3_r1", 32'(wbQ[1]), 32'h1_FFFF);
    checkOutput("t3_r2", 32'(wbQ[2]), 32'h2_FFFF);
    checkOutput("t3_mfhi", 32'(wbQ[3]), 32'h5_FFFE);
    checkOutput("t3_mflo", 32'(wbQ[4]), 32'h6_0001);
    checkOutput("t3_mul_gap", 32'(wbCyc[3] - wbCyc[2]), 32'd23);

    // BEQ taken/not taken, JMP, PC wrap through NOP at 0xFFF.
    applyStimulus(1'b1, 2);
    clearMem();
    mem[0]      = 16'h4071;
    mem[1]      = 16'h4072;
    mem[2]      = 16'h40F3;
    mem[3]      = 16'h43F3;
    mem[4]      = 16'h4323;
    mem[5]      = 16'h8123;
    mem[12'h020] = 16'h8143;
    mem[12'h021] = 16'h9ABC;
    mem[12'hABC] = 16'h9FFF;
    mem[12'hFFF] = 16'hA000;
    expFetch = '{12'h000, 12'h001, 12'h002, 12'h003, 12'h004, 12'h005,
                 12'h020, 12'h021, 12'hABC, 12'hFFF, 12'h000};
    clearLogs();
    applyStimulus(1'b0, 1);
    for (int i = 0; i < 300 && fetchQ.size() < 11; i++) applyStimulus(1'b0, 1);
    checkOutput("t4_fetch_count", 32'(fetchQ.size() >= 11), 32'h1);
    for (int i = 0; i < 11; i++) begin
      checkOutput($sformatf("t4_fetch%0d", i), 32'(fetchQ[i]), 32'(expFetch[i]));
    end
    checkOutput("t4_r3_target", 32'(wbQ[4]), 32'h3_0020);

    // Reset in the middle of a multiply.
    applyStimulus(1'b1, 2);
    clearMem();
    mem[0] = 16'h4031;
    mem[1] = 16'h4052;
    mem[2] = 16'h5120;
    mem[3] = 16'hF000;
    clearLogs();
    applyStimulus(1'b0, 1);
    applyStimulus(1'b0, 14);
    checkOutput("t5_in_mult_pc", 32'(pc), 32'h2);
    mem[0] = 16'h6005;
    mem[1] = 16'h7006;
    mem[2] = 16'h0127;
    mem[3] = 16'hF000;
    clearLogs();
    applyStimulus(1'b1, 1);
    checkOutput("t5_rst_pc", 32'(pc), 32'h0);
    checkOutput("t5_rst_req", 32'(bus.imem_req), 32'h0);
    checkOutput("t5_rst_wb_valid", 32'(wbValid), 32'h0);
    checkOutput("t5_rst_no_wb", 32'(wbQ.size()), 32'd0);
    applyStimulus(1'b0, 1);
    runUntilHalt(300);
    checkOutput("t5_wb_count", 32'(wbQ.size()), 32'd3);
    checkOutput("t5_hi_zero", 32'(wbQ[0]), 32'h5_0000);
    checkOutput("t5_lo_zero", 32'(wbQ[1]), 32'h6_0000);
    checkOutput("t5_regs_zero", 32'(wbQ[2]), 32'h7_0000);

    // Reset while a fetch is stalled waiting for ack.
    applyStimulus(1'b1, 2);
    clearMem();
    mem[0] = 16'h4051;
    mem[1] = 16'h4032;
    mem[2] = 16'h0123;
    mem[3] = 16'hF000;
    clearLogs();
    applyStimulus(1'b0, 1);
    applyStimulus(1'b0, 3);
    holdAck = 1'b1;
    applyStimulus(1'b0, 4);
    checkOutput("t6_wait_pc", 32'(pc), 32'h1);
    checkOutput("t6_wait_req", 32'(bus.imem_req), 32'h1);
    checkOutput("t6_wait_addr", 32'(bus.imem_addr), 32'h1);
    checkOutput("t6_wait_wb_count", 32'(wbQ.size()), 32'd1);
    applyStimulus(1'b1, 1);
    checkOutput("t6_rst_pc", 32'(pc), 32'h0);
    checkOutput("t6_rst_req", 32'(bus.imem_req), 32'h0);
    checkOutput("t6_rst_wb_valid", 32'(wbValid), 32'h0);
    holdAck = 1'b0;
    clearLogs();
    applyStimulus(1'b0, 1);
    runUntilHalt(300);
    checkOutput("t6_rerun_wb_count", 32'(wbQ.size()), 32'd3);
    checkOutput("t6_rerun_wb2", 32'(wbQ[2]), 32'h3_0008);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/mcpu_core.md
# mcpu_core

Parametrised multicycle processor core, the next generation of the team's 16-bit microprocessor. It fetches 16-bit instructions over a req/ack instruction-memory port that tolerates wait states, so it is no longer tied to a single-cycle ROM. It executes through an explicit FSM with a generic register file and adds an iterative HI/LO multiplier, a HALT state and a write-back observation port. It sits between the instruction memory and the board/testbench top.

## Interface
- DW, 16: datapath/register width; ≥16
- AW, 12: PC and instruction-address width; ≥12
- NREG, 16: register count; fixed at 16 (4-bit fields)
- CLK  in  1  clock, rising edge
- RST  in  1  reset, synchronous, active-high
- imem_req  out  1  fetch request
- imem_addr  out  AW  fetch address (= pc)
- imem_ack  in  1  fetch data valid this cycle
- imem_rdata  in  16  instruction word
- pc  out  AW  current PC
- halted  out  1  core in HALT
- wb_valid  out  1  register write this cycle
- wb_addr  out  4  written register
- wb_data  out  DW  written value

## Operation
- Instruction fields: op=[15:12], a=[11:8], b=[7:4], c=[3:0], imm12=[11:0].
- Opcodes:
  - 0 ADD: R[c]=R[a]+R[b]
  - 1 SUB: R[c]=R[a]-R[b]
  - 2 AND
  - 3 OR
  - 4 ADDI: R[c]=R[a]+zext(b)
  - 5 MUL: {HI,LO}=R[a]*R[b], unsigned, 2·DW result
  - 6 MFHI: R[c]=HI
  - 7 MFLO: R[c]=LO
  - 8 BEQ: if R[a]==R[b], PC=R[c][AW-1:0], else PC+1
  - 9 JMP: PC={PC[AW-1:12],imm12}
  - F HALT
  - A–E: NOP, PC+1
- Arithmetic is modulo 2^DW; no flags are exported. R0 is an ordinary register.
- FSM states: FETCH, DECODE, EXEC, MULT, WB, HALT.
  - FETCH: imem_req=1, imem_addr=pc. On imem_ack, latch IR and go to DECODE.
  - DECODE: read R[a] and R[b] into operand latches.
  - EXEC:
    - ALU, ADDI and MFHI/MFLO: compute result and go to WB.
    - MUL: load multiplier and go to MULT.
    - BEQ, JMP and NOP: update PC and go to FETCH.
    - HALT: go to HALT.
  - MULT: shift-add, one bit per cycle, DW cycles. On the last cycle write HI/LO, pc+1, and go to FETCH.
  - WB: write R[c], pulse wb_*, pc+1, and go to FETCH.
  - HALT: terminal until RST; imem_req=0.
- imem_req and imem_addr stay stable until ack. imem_ack outside FETCH is ignored.
- pc+1 wraps modulo 2^AW.

## Timing
- Reset values: pc=0, imem_req=0, halted=0, wb_valid=0, wb_addr=0, wb_data=0. All registers, HI, LO and IR are 0. State is FETCH, with req asserting the cycle after RST deasserts.
- RST has priority in every state, including mid-MULT and mid-wait. It aborts the operation with no partial writes.
- Zero-wait latency: ALU/ADDI/MF = 4 cycles; branch/JMP/NOP = 3 cycles; MUL = 3+DW cycles. Each memory wait cycle adds 1.
- imem_ack may arrive in the same cycle req first rises.
- wb_valid is a one-cycle pulse in WB. The register-file write is visible to the next instruction's DECODE.
- BEQ decision uses DECODE-latched operands; the branch target is read the same cycle.

## Structure
- Package mcpu_pkg holds:
  - opcode localparams
  - state enum
  - field-slice constants
- Sub-module mcpu_regfile: 16×DW, two combinational read ports, one synchronous write port, synchronous reset to 0.
- The multiplier stays inline in mcpu_core as an FSM-driven shift-add.

## Test plan
- Zero-wait program: ADDI R1=R0+5; ADDI R2=R0+3; ADD R3=R1+R2 -> wb sequence (1,5),(2,3),(3,8); pc=3 after 12 cycles.
- Random 0–3 wait states on ack -> identical wb sequence; req and addr held stable while ack is low.
- MUL with R1=0xFFFF, R2=0xFFFF (DW=16) -> after 19 cycles, MFHI gives 0xFFFE and MFLO gives 0x0001.
- BEQ taken (R1==R2, R3=0x020) -> next fetch addr 0x020. Not taken -> pc+1. JMP 0xABC -> addr 0xABC.
- pc=0xFFF with NOP -> wraps to 0x000. HALT -> halted=1, req stays 0 for 100 cycles.
- RST asserted mid-MULT and mid-fetch-wait -> next cycle pc=0, req=0, no wb_valid, HI/LO=0.
